lifo_stack_param: RTL

Parametrised LIFO (stack) with configurable data width and depth. Adds a registered output-valid strobe, an occupancy count, an almost-full threshold, a same-cycle push+pop (replace-top) mode and sticky overflow/underflow error flags. It serves as the general-purpose stack primitive in the Data Storage library, for return-address stacks, expression evaluation and any parser that needs bounded last-in-first-out buffering.

---
 rtl/lifo_stack_param.sv | 105 ++++++++++
 1 files changed

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with registered read port, occupancy count,
// almost-full threshold, replace-top mode and sticky error flags.
module lifo_stack_param #(
    parameter int DATA_WIDTH        = 32,
    parameter int DEPTH             = 8,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
    localparam int CW               = $clog2(DEPTH + 1)
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Push_In,
    input  logic                  Pop_In,
    input  logic                  Peek_In,
    input  logic                  Clear_Err_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Data_Valid_Out,
    output logic [CW-1:0]         Count_Out,
    output logic                  LIFO_Empty,
    output logic                  LIFO_Full,
    output logic                  LIFO_Almost_Full,
    output logic                  Overflow_Out,
    output logic                  Underflow_Out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0] top_data;
    logic                  is_empty;
    logic                  is_full;
    logic                  do_replace;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_peek;
    logic                  do_read;
    logic                  set_ovf;
    logic                  set_unf;
    logic [CW-1:0]         sp_next;

    always_comb begin
        is_empty   = (Count_Out == '0);
        is_full    = (Count_Out == DEPTH_C);
        top_idx    = AW'(Count_Out - 1'b1);
        wr_idx     = AW'(Count_Out);
        top_data   = mem[top_idx];

        do_replace = Push_In & Pop_In & !is_empty;
        // A push paired with a pop on an empty stack still lands in mem[0].
        do_push    = Push_In & ((Pop_In & is_empty) | (!Pop_In & !is_full));
        do_pop     = Pop_In & !Push_In & !is_empty;
        do_peek    = Peek_In & !Pop_In & !is_empty;
        do_read    = do_replace | do_pop | do_peek;

        set_ovf    = Push_In & !Pop_In & is_full;
        set_unf    = is_empty & (Pop_In | Peek_In);

        sp_next = Count_Out;
        if (do_push) begin
            sp_next = Count_Out + 1'b1;
        end else if (do_pop) begin
            sp_next = Count_Out - 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge Clk_In) begin
        if (do_replace) begin
            mem[top_idx] <= Data_In;
        end else if (do_push) begin
            mem[wr_idx] <= Data_In;
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            Count_Out        <= '0;
            Data_Out         <= '0;
            Data_Valid_Out   <= 1'b0;
            LIFO_Empty       <= 1'b1;
            LIFO_Full        <= 1'b0;
            LIFO_Almost_Full <= 1'b0;
            Overflow_Out     <= 1'b0;
            Underflow_Out    <= 1'b0;
        end else begin
            Count_Out        <= sp_next;
            Data_Valid_Out   <= do_read;
            LIFO_Empty       <= (sp_next == '0);
            LIFO_Full        <= (sp_next == DEPTH_C);
            LIFO_Almost_Full <= (sp_next >= AF_C);
            if (do_read) begin
                Data_Out <= top_data;
            end
            // A flag raised this cycle survives a simultaneous clear.
            Overflow_Out  <= set_ovf | (Overflow_Out & !Clear_Err_In);
            Underflow_Out <= set_unf | (Underflow_Out & !Clear_Err_In);
        end
    end

endmodule
